// File: rtl/cic_decimator_if.sv
// Sample-stream bundle between the NCO/mixer, the CIC decimator and the next receive stage.
// Upstream drives the full-rate I/Q side; downstream consumes the decimated side.
interface cic_decimator_if #(
  parameter int IN_WIDTH  = 22,
  parameter int OUT_WIDTH = 24
);
  logic                        in_strobe;
  logic signed [IN_WIDTH-1:0]  in_I;
  logic signed [IN_WIDTH-1:0]  in_Q;
  logic                        out_strobe;
  logic signed [OUT_WIDTH-1:0] out_I;
  logic signed [OUT_WIDTH-1:0] out_Q;

  modport master (output in_strobe, in_I, in_Q, input out_strobe, out_I, out_Q);
  modport slave  (input in_strobe, in_I, in_Q, output out_strobe, out_I, out_Q);
endinterface

// File: rtl/cic_decimator.sv
// Five-stage CIC decimator for receive I/Q: one datapath lane per component, shared
// sample counter and comb valid pipeline, round-half-up with positive saturation.
module cic_lane #(
  parameter int IN_WIDTH  = 22,
  parameter int OUT_WIDTH = 24,
  parameter int STAGES    = 5,
  parameter int ACC_WIDTH = 42
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_strobe_i,
  input  logic                        dec_evt_i,
  input  logic [STAGES:0]             vld_pipe_i,
  input  logic signed [IN_WIDTH-1:0]  x_i,
  output logic signed [OUT_WIDTH-1:0] y_o
);
  localparam int SH = ACC_WIDTH - OUT_WIDTH;
  localparam logic signed [OUT_WIDTH-1:0] MAXP = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  logic signed [ACC_WIDTH-1:0] integ_q [STAGES];
  logic signed [ACC_WIDTH-1:0] comb_q  [STAGES];
  logic signed [ACC_WIDTH-1:0] dly_q   [STAGES];
  logic signed [ACC_WIDTH-1:0] comb_in_q;
  logic signed [ACC_WIDTH-1:0] x_ext;
  logic signed [OUT_WIDTH-1:0] y_q, y_d, top;
  logic                        rnd;
  logic                        unused_lsbs;

  assign x_ext       = {{(ACC_WIDTH-IN_WIDTH){x_i[IN_WIDTH-1]}}, x_i};
  assign unused_lsbs = ^comb_q[STAGES-1][SH-2:0];

  // Keep the top OUT_WIDTH bits, add the next bit down; only the max-positive code can overflow.
  always_comb begin
    top = comb_q[STAGES-1][ACC_WIDTH-1 -: OUT_WIDTH];
    rnd = comb_q[STAGES-1][SH-1];
    y_d = top + {{(OUT_WIDTH-1){1'b0}}, rnd};
    if (rnd && top == MAXP) y_d = MAXP;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
      comb_in_q <= '0;
      y_q       <= '0;
    end else begin
      // Integrators wrap freely; the comb differences undo the wrap exactly.
      if (in_strobe_i) begin
        integ_q[0] <= integ_q[0] + x_ext;
        for (int k = 1; k < STAGES; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
      if (dec_evt_i) comb_in_q <= integ_q[STAGES-1];
      if (vld_pipe_i[0]) begin
        comb_q[0] <= comb_in_q - dly_q[0];
        dly_q[0]  <= comb_in_q;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (vld_pipe_i[k]) begin
          comb_q[k] <= comb_q[k-1] - dly_q[k];
          dly_q[k]  <= comb_q[k-1];
        end
      end
      if (vld_pipe_i[STAGES]) y_q <= y_d;
    end
  end

  assign y_o = y_q;
endmodule

module cic_decimator #(
  parameter int IN_WIDTH   = 22,
  parameter int OUT_WIDTH  = 24,
  parameter int STAGES     = 5,
  parameter int DECIMATION = 16
) (
  input  logic      clock,
  input  logic      reset,
  cic_decimator_if.slave bus
);
  localparam int CNT_W     = $clog2(DECIMATION);
  localparam int ACC_WIDTH = IN_WIDTH + STAGES * CNT_W;
  localparam int NUM_LANES = 2;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STAGES:0]    vld_pipe_q, vld_pipe_d;
  logic               out_strobe_q;
  logic               dec_evt;
  logic [NUM_LANES-1:0][IN_WIDTH-1:0]  lane_in;
  logic [NUM_LANES-1:0][OUT_WIDTH-1:0] lane_out;

  assign dec_evt = bus.in_strobe && (cnt_q == CNT_W'(DECIMATION - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (bus.in_strobe) cnt_d = dec_evt ? '0 : cnt_q + CNT_W'(1);
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], dec_evt};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      vld_pipe_q   <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      vld_pipe_q   <= vld_pipe_d;
      out_strobe_q <= vld_pipe_q[STAGES];
    end
  end

  assign lane_in = {bus.in_Q, bus.in_I};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cic_lane #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .STAGES   (STAGES),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clock      (clock),
      .reset      (reset),
      .in_strobe_i(bus.in_strobe),
      .dec_evt_i  (dec_evt),
      .vld_pipe_i (vld_pipe_q),
      .x_i        (lane_in[g]),
      .y_o        (lane_out[g])
    );
  end

  assign bus.out_strobe = out_strobe_q;
  assign bus.out_I      = lane_out[0];
  assign bus.out_Q      = lane_out[1];
endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: a DECIMATION=16 and a DECIMATION=2 instance share stimulus and are
// compared every cycle against a closed-form CIC model (binomial-weighted sums, modular wrap).
module tb_cic_decimator;
  localparam int S  = 5;
  localparam int IW = 22;
  localparam int OW = 24;

  logic clock = 1'b0;
  logic reset;
  logic stb;
  logic signed [IW-1:0] in_i, in_q;

  cic_decimator_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus0 ();
  cic_decimator_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus1 ();

  assign bus0.in_strobe = stb;
  assign bus0.in_I      = in_i;
  assign bus0.in_Q      = in_q;
  assign bus1.in_strobe = stb;
  assign bus1.in_I      = in_i;
  assign bus1.in_Q      = in_q;

  cic_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .STAGES(S), .DECIMATION(16)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  cic_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .STAGES(S), .DECIMATION(2)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  initial forever #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int     dec_r [2];
  int     acc_w [2];
  longint hx_i [4096];
  longint hx_q [4096];
  int     cnt;
  longint sv_i [2][2048];
  longint sv_q [2][2048];
  int     nev [2];
  bit     due_v [2][16];
  longint due_i [2][16];
  longint due_q [2][16];
  longint held_i [2];
  longint held_q [2];
  bit     exp_stb [2];
  int     edge_n;
  int     ev16_edge;
  int     first_stb_edge;
  int     last_stb_edge [2];
  bit     spacing_on;
  int     win_strobes;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint binom(longint n, int k);
    longint r = 1;
    if (n < k) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Last integrator value just before the t-th accepted sample: sum x[m]*C(t-m-1, S-1).
  function automatic longint integ_sum(bit q);
    longint s = 0;
    for (int m = 0; m < cnt; m++) s += (q ? hx_q[m] : hx_i[m]) * binom(cnt - m - 1, S - 1);
    return s;
  endfunction

  // S-th order difference of decimated samples, reduced to the accumulator width, then scaled.
  function automatic longint model_out(int d, bit q);
    longint c = 0;
    longint top, r, maxp;
    int a = acc_w[d];
    int j = nev[d];
    for (int i = 0; i <= S; i++)
      if (j - i >= 0)
        c += ((i % 2) ? -1 : 1) * binom(S, i) * (q ? sv_q[d][j-i] : sv_i[d][j-i]);
    c    = (c <<< (64 - a)) >>> (64 - a);
    top  = c >>> (a - OW);
    r    = (c >>> (a - OW - 1)) & 1;
    maxp = (64'sd1 <<< (OW - 1)) - 1;
    return (top == maxp && r == 1) ? maxp : top + r;
  endfunction

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        nev[d] = 0; held_i[d] = 0; held_q[d] = 0;
        for (int k = 0; k < 16; k++) due_v[d][k] = 0;
      end else if (stb && (cnt % dec_r[d] == dec_r[d] - 1)) begin
        int slot;
        slot = (edge_n + 1 + S + 1) % 16;
        sv_i[d][nev[d]] = integ_sum(0);
        sv_q[d][nev[d]] = integ_sum(1);
        due_v[d][slot] = 1;
        due_i[d][slot] = model_out(d, 0);
        due_q[d][slot] = model_out(d, 1);
        nev[d]++;
        if (d == 0 && cnt == dec_r[0] - 1) ev16_edge = edge_n + 1;
      end
    end
    if (reset) cnt = 0;
    else if (stb) begin
      hx_i[cnt] = in_i;
      hx_q[cnt] = in_q;
      cnt++;
    end
    @(posedge clock);
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      exp_stb[d] = due_v[d][edge_n % 16];
      if (exp_stb[d]) begin
        held_i[d] = due_i[d][edge_n % 16];
        held_q[d] = due_q[d][edge_n % 16];
        due_v[d][edge_n % 16] = 0;
      end
    end
    @(negedge clock);
    chk("d16_strobe", bus0.out_strobe, exp_stb[0]);
    chk("d16_out_I", bus0.out_I, held_i[0]);
    chk("d16_out_Q", bus0.out_Q, held_q[0]);
    chk("d2_strobe", bus1.out_strobe, exp_stb[1]);
    chk("d2_out_I", bus1.out_I, held_i[1]);
    chk("d2_out_Q", bus1.out_Q, held_q[1]);
    if (bus0.out_strobe === 1'b1) begin
      if (first_stb_edge < 0) first_stb_edge = edge_n;
      if (spacing_on && last_stb_edge[0] >= 0) chk("d16_spacing", edge_n - last_stb_edge[0], 16);
      last_stb_edge[0] = edge_n;
      win_strobes++;
    end
    if (bus1.out_strobe === 1'b1) begin
      if (spacing_on && last_stb_edge[1] >= 0) chk("d2_spacing", edge_n - last_stb_edge[1], 2);
      last_stb_edge[1] = edge_n;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    first_stb_edge   = -1;
    last_stb_edge[0] = -1;
    last_stb_edge[1] = -1;
  endtask

  initial begin
    dec_r[0] = 16; dec_r[1] = 2;
    acc_w[0] = IW + S * 4; acc_w[1] = IW + S * 1;
    cnt = 0; edge_n = 0; ev16_edge = -100; spacing_on = 0; win_strobes = 0;
    for (int d = 0; d < 2; d++) begin
      nev[d] = 0; held_i[d] = 0; held_q[d] = 0;
      for (int k = 0; k < 16; k++) due_v[d][k] = 0;
    end

    // Reset held with strobe and data active.
    stb = 1'b1; in_i = 22'sd5000; in_q = 22'sd5000;
    do_reset(3);

    // DC gain, latency and strobe spacing with continuous strobe.
    in_i = 22'sd1000; in_q = -22'sd3; spacing_on = 1;
    tick();
    chk("post_rst_strobe", bus0.out_strobe, 0);
    chk("post_rst_out_I", bus0.out_I, 0);
    chk("post_rst_out_Q", bus0.out_Q, 0);
    repeat (199) tick();
    chk("dc16_I", bus0.out_I, 4000);
    chk("dc16_Q", bus0.out_Q, -12);
    chk("dc2_I", bus1.out_I, 4000);
    chk("dc2_Q", bus1.out_Q, -12);
    chk("latency", first_stb_edge - ev16_edge, 6);
    spacing_on = 0;

    // Random full-scale data with random strobe: exercises integrator wrap.
    repeat (300) begin
      stb  = 1'($urandom_range(0, 1));
      in_i = IW'($urandom);
      in_q = IW'($urandom);
      tick();
    end

    // Full-scale positive and negative DC.
    do_reset(1);
    stb = 1'b1; in_i = 22'sd2097151; in_q = -22'sd2097152;
    repeat (200) tick();
    chk("sat16_I", bus0.out_I, 8388604);
    chk("sat16_Q", bus0.out_Q, -8388608);
    chk("sat2_I", bus1.out_I, 8388604);
    chk("sat2_Q", bus1.out_Q, -8388608);

    // Strobe gaps at ~30% duty.
    do_reset(1);
    in_i = 22'sd1000; in_q = 22'sd1000;
    repeat (600) begin
      stb = ($urandom_range(0, 99) < 30);
      tick();
    end
    chk("gap_I", bus0.out_I, 4000);
    chk("gap_Q", bus0.out_Q, 4000);

    // Reset between a decimation event and its output.
    do_reset(1);
    stb = 1'b1; in_i = 22'sd777; in_q = -22'sd777;
    for (int i = 0; i < 16 && (cnt % 16) != 15; i++) tick();
    tick();
    tick();
    tick();
    do_reset(1);
    win_strobes = 0;
    repeat (12) tick();
    chk("midrst_strobes", win_strobes, 0);
    chk("midrst_out_I", bus0.out_I, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cic_decimator.md
# cic_decimator

Five-stage CIC decimator for the I and Q outputs of the receive NCO/mixer stage. It takes full-rate signed I/Q samples qualified by an input strobe and produces one I/Q pair per DECIMATION input samples. The output carries a single-cycle output strobe and is rounded and saturated to OUT_WIDTH. It sits directly downstream of the NCO/mixer and feeds the next decimation/FIR stage of the receiver chain.

## Interface
- IN_WIDTH, 22: input sample width; matches mixer I/Q output width.
- OUT_WIDTH, 24: output sample width.
- STAGES, 5: number of integrator and comb stages; differential delay fixed at 1.
- DECIMATION, 16: decimation ratio; legal range 2..256.
- ACC_WIDTH (localparam): IN_WIDTH + STAGES*ceil(log2(DECIMATION)); 42 at defaults.
- clock  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in_strobe  input  1  in_I/in_Q valid this cycle; may be high every cycle.
- in_I  input  IN_WIDTH  signed I sample.
- in_Q  input  IN_WIDTH  signed Q sample.
- out_strobe  output  1  one-cycle pulse; out_I/out_Q are new this cycle.
- out_I  output  OUT_WIDTH  signed decimated I; held between strobes.
- out_Q  output  OUT_WIDTH  signed decimated Q; held between strobes.

## Operation
- I and Q use identical, independent datapaths with shared control (counter, valid pipeline).
- Integrators: ACC_WIDTH registers, two's-complement wrap-around. No saturation; wrap is required for correctness.
  - On each in_strobe edge, integ[0] <= integ[0] + sign-extended input.
  - On the same edge, integ[k] <= integ[k] + integ[k-1], using pre-edge values, so the chain is pipelined.
  - Without in_strobe, all integrators hold.
- Sample counter, 0..DECIMATION-1: increments on in_strobe and wraps to 0.
  - Decimation event: in_strobe high with counter == DECIMATION-1.
  - At that edge, comb input register <= integ[STAGES-1] (pre-edge value) and cvalid[0] is set.
- Combs: stage k updates only when cvalid[k] is high.
  - comb[k] <= x - dly[k]; dly[k] <= x, where x is the previous comb output (or the comb input register for k=0).
  - cvalid shifts one stage per clock, so the combs advance one stage per clock.
- Output scaling, taking the final comb value c:
  - Keep c[ACC_WIDTH-1 : ACC_WIDTH-OUT_WIDTH] and add rounding bit c[ACC_WIDTH-OUT_WIDTH-1] (round half up).
  - If rounding overflows past max positive, saturate to 2^(OUT_WIDTH-1)-1.
  - Negative values never saturate.
- DC gain: DECIMATION^STAGES / 2^(ACC_WIDTH-OUT_WIDTH). At defaults this is 2^20 / 2^18 = 4.
- Reset: all integrators, comb and delay registers, counter, cvalid, out_I, out_Q and out_strobe go to 0 at the next edge.
  - Reset wins over in_strobe.
  - After reset the first decimation event occurs on the DECIMATION-th strobe.
  - The first STAGES outputs after reset are filter transient, not errors.

## Timing
- Decimation event at edge E0: comb stage k registers at edge E0+1+k.
- out_I/out_Q register at edge E0+STAGES+1, and out_strobe is high for exactly the cycle following that edge. At defaults that is 6 clocks after the event edge.
- out_strobe is never high for two consecutive cycles.
- Output period equals DECIMATION in_strobe pulses. With in_strobe tied high, out_strobe period is exactly DECIMATION clocks.
- Consecutive decimation events may be as close as 2 clocks (DECIMATION=2, continuous strobe). Comb pipeline stages stay independent, so no data is lost.
- in_strobe gaps stretch the period and do not corrupt state.
- Reset asserted mid-comb pipeline: the in-flight sample is discarded and no out_strobe is produced for it.

## Test plan
- Reset/idle: assert reset 3 cycles with in_strobe high, in_I=5000 → out_I=out_Q=0 and out_strobe=0 throughout and on the first cycle after release.
- DC gain: defaults, in_strobe=1, in_I=1000, in_Q=-3 for 200 clocks → from the 7th out_strobe onward, out_I=4000 and out_Q=-12. Strobe spacing is exactly 16 clocks.
- Latency: defaults, continuous strobe → out_strobe first rises exactly 6 clocks after the edge where the 16th post-reset strobe is sampled.
- Saturation/wrap: in_I=+2^21-1 constant → steady out_I=8388604, no wrap glitches. in_I=-2^21 constant → out_I=-8388608.
- Strobe gaps: in_strobe random 30% duty, in_I=1000 → steady out_I=4000, one out_strobe per 16 accepted samples.
- Mid-operation reset and DECIMATION=2 build: reset pulsed between event and output → no out_strobe for that sample. DECIMATION=2, STAGES=5, continuous strobe → out_strobe every 2 clocks, DC gain matches formula.
